// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: status-byte bit positions,
// the decoded packet held between pipeline stages, and movement decode.
package mouse_pkg;

    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_M   = 2;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    typedef struct packed {
        logic l, r, m, good;
        logic signed [8:0] dx, dy;
    } mouse_pkt_t;

    // An overflowed axis reports a meaningless byte, so pin it to the extreme
    // of the 9-bit range in the reported direction.
    function automatic logic signed [8:0] decode_delta(
        input logic       sign,
        input logic       ovf,
        input logic [7:0] mag
    );
        logic signed [8:0] d;
        if (ovf) begin
            d = sign ? 9'sh100 : 9'sh0FF;
        end else begin
            d = {sign, mag};
        end
        return d;
    endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: integrates a signed delta into a position clamped to
// 0..MAX-1, with a centre request taking priority over the update.
module mouse_axis_accum #(
    parameter int MAX    = 160,
    parameter int POS_W  = 10,
    parameter bit INVERT = 1'b0
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic signed [8:0]       delta_i,
    input  logic                    upd_i,
    input  logic                    centre_i,
    output logic        [POS_W-1:0] pos_o
);

    localparam logic        [POS_W-1:0] CENTRE = POS_W'(MAX / 2);
    localparam logic signed [POS_W+1:0] HI     = (POS_W + 2)'(MAX - 1);

    logic        [POS_W-1:0] pos_q, pos_d;
    logic signed [POS_W+1:0] pos_ext, delta_ext, sum;

    always_comb begin
        pos_ext   = $signed({2'b00, pos_q});
        delta_ext = {{(POS_W - 7){delta_i[8]}}, delta_i};
        sum       = INVERT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        pos_d     = pos_q;
        if (centre_i) begin
            pos_d = CENTRE;
        end else if (upd_i) begin
            if (sum < 0) begin
                pos_d = '0;
            end else if (sum > HI) begin
                pos_d = HI[POS_W-1:0];
            end else begin
                pos_d = sum[POS_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= CENTRE;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet tracker: validates packets, decodes buttons and movement,
// and maintains a clamped absolute cursor position (x right, y down).
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int MAX_X = 160,
    parameter int MAX_Y = 120,
    parameter int POS_W = 10
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             ps2pkt_vld,
    input  logic [23:0]      ps2pkt_data,
    input  logic             centre_req,
    output logic [POS_W-1:0] mouse_x,
    output logic [POS_W-1:0] mouse_y,
    output logic             btn_l,
    output logic             btn_r,
    output logic             btn_m,
    output logic             pos_vld,
    output logic             pkt_err,
    output logic [7:0]       err_cnt
);

    mouse_pkt_t s1_pkt_q, s1_pkt_d;
    logic       s1_vld_q;
    logic [2:0] btn_q;
    logic       pos_vld_q, pkt_err_q;
    logic [7:0] err_cnt_q;
    logic       upd, bad;

    always_comb begin
        s1_pkt_d      = '0;
        s1_pkt_d.l    = ps2pkt_data[BTN_L];
        s1_pkt_d.r    = ps2pkt_data[BTN_R];
        s1_pkt_d.m    = ps2pkt_data[BTN_M];
        s1_pkt_d.good = ps2pkt_data[ALWAYS1];
        s1_pkt_d.dx   = decode_delta(ps2pkt_data[XSIGN], ps2pkt_data[XOVF], ps2pkt_data[15:8]);
        s1_pkt_d.dy   = decode_delta(ps2pkt_data[YSIGN], ps2pkt_data[YOVF], ps2pkt_data[23:16]);
    end

    assign upd = s1_vld_q &  s1_pkt_q.good;
    assign bad = s1_vld_q & ~s1_pkt_q.good;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_pkt_q  <= '0;
            btn_q     <= '0;
            pos_vld_q <= 1'b0;
            pkt_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s1_vld_q <= ps2pkt_vld;
            if (ps2pkt_vld) begin
                s1_pkt_q <= s1_pkt_d;
            end
            pos_vld_q <= upd;
            pkt_err_q <= bad;
            if (upd) begin
                btn_q <= {s1_pkt_q.m, s1_pkt_q.r, s1_pkt_q.l};
            end
            if (bad && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // PS/2 reports +y as up while the screen grows downward, hence INVERT on y.
    mouse_axis_accum #(
        .MAX   (MAX_X),
        .POS_W (POS_W),
        .INVERT(1'b0)
    ) u_acc_x (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .delta_i (s1_pkt_q.dx),
        .upd_i   (upd),
        .centre_i(centre_req),
        .pos_o   (mouse_x)
    );

    mouse_axis_accum #(
        .MAX   (MAX_Y),
        .POS_W (POS_W),
        .INVERT(1'b1)
    ) u_acc_y (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .delta_i (s1_pkt_q.dy),
        .upd_i   (upd),
        .centre_i(centre_req),
        .pos_o   (mouse_y)
    );

    assign btn_l   = btn_q[0];
    assign btn_r   = btn_q[1];
    assign btn_m   = btn_q[2];
    assign pos_vld = pos_vld_q;
    assign pkt_err = pkt_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: a behavioural cursor model queues the
// expected response per packet; a negedge monitor checks each DUT pulse.
module tb_mouse_tracker;

    localparam int MAX_X = 160;
    localparam int MAX_Y = 120;
    localparam int POS_W = 10;

    logic             clk_sys = 1'b0;
    logic             rst_n = 1'b0;
    logic             ps2pkt_vld = 1'b0;
    logic [23:0]      ps2pkt_data = '0;
    logic             centre_req = 1'b0;
    logic [POS_W-1:0] mouse_x, mouse_y;
    logic             btn_l, btn_r, btn_m, pos_vld, pkt_err;
    logic [7:0]       err_cnt;

    mouse_tracker #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .POS_W(POS_W)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .ps2pkt_vld (ps2pkt_vld),
        .ps2pkt_data(ps2pkt_data),
        .centre_req (centre_req),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_m      (btn_m),
        .pos_vld    (pos_vld),
        .pkt_err    (pkt_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit good;
        int x, y;
        bit l, r, m;
        int ec;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // behavioural model state
    int mx, my, mec;
    bit ml, mr, mm;
    bit cen_pending = 1'b0;

    function automatic void chk(string name, int act, int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic int clampi(int v, int max);
        if (v < 0) return 0;
        if (v > max - 1) return max - 1;
        return v;
    endfunction

    function automatic int delta_of(bit sign, bit ovf, logic [7:0] b);
        if (ovf) return sign ? -256 : 255;
        return sign ? int'(b) - 256 : int'(b);
    endfunction

    task automatic model_reset();
        mx = MAX_X / 2; my = MAX_Y / 2; mec = 0;
        ml = 0; mr = 0; mm = 0;
    endtask

    task automatic model_pkt(input logic [23:0] d, input bit cen, input int k);
        exp_t e;
        logic [7:0] st;
        st = d[7:0];
        if (st[3]) begin
            mx = clampi(mx + delta_of(st[4], st[6], d[15:8]), MAX_X);
            my = clampi(my - delta_of(st[5], st[7], d[23:16]), MAX_Y);
            ml = st[0]; mr = st[1]; mm = st[2];
        end else if (mec < 255) begin
            mec++;
        end
        if (cen) begin
            mx = MAX_X / 2; my = MAX_Y / 2;
        end
        e.cyc = k + 2; e.good = st[3];
        e.x = mx; e.y = my; e.l = ml; e.r = mr; e.m = mm; e.ec = mec;
        expq.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (rst_n) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missing_pulse: no pulse at cycle %0d", expq[0].cyc);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                chk("pos_vld", int'(pos_vld), int'(e.good));
                chk("pkt_err", int'(pkt_err), int'(!e.good));
                chk("mouse_x", int'(mouse_x), e.x);
                chk("mouse_y", int'(mouse_y), e.y);
                chk("btns", int'({btn_m, btn_r, btn_l}), int'({e.m, e.r, e.l}));
                chk("err_cnt", int'(err_cnt), e.ec);
            end else begin
                chk("spurious_pulse", int'({pos_vld, pkt_err}), 0);
            end
        end
    end

    task automatic drive_cycle(input bit vld, input logic [23:0] data, input bit cen_next);
        @(posedge clk_sys); #1;
        ps2pkt_vld  = vld;
        ps2pkt_data = data;
        centre_req  = cen_pending;
        cen_pending = cen_next;
        if (vld) model_pkt(data, cen_next, cyc);
        else if (cen_next) begin
            mx = MAX_X / 2; my = MAX_Y / 2;
        end
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        drive_cycle(1'b1, {dy, dx, st}, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 24'h0, 1'b0);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_sys); #1;
        rst_n = 1'b0;
        expq.delete();
        model_reset();
        cen_pending = 1'b0;
        @(posedge clk_sys); #1;
        ps2pkt_vld = 1'b0;
        centre_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_x"}, int'(mouse_x), mx);
        chk({tag, "_y"}, int'(mouse_y), my);
        chk({tag, "_btn"}, int'({btn_m, btn_r, btn_l}), int'({mm, mr, ml}));
        chk({tag, "_err_cnt"}, int'(err_cnt), mec);
        chk({tag, "_pulses"}, int'({pos_vld, pkt_err}), 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
        check_state("reset");
        chk("reset_x_abs", int'(mouse_x), 80);
        chk("reset_y_abs", int'(mouse_y), 60);

        send(8'h09, 8'h05, 8'h03);
        idle(4);
        check_state("basic");
        chk("basic_x_abs", int'(mouse_x), 85);
        chk("basic_y_abs", int'(mouse_y), 57);

        do_reset();
        send(8'h18, 8'hF6, 8'h00);
        idle(4);
        check_state("neg_dx");
        send(8'h28, 8'h00, 8'hFB);
        idle(4);
        check_state("neg_dy");
        chk("neg_dy_abs", int'(mouse_y), 65);

        do_reset();
        send(8'h08, 8'd70, 8'h00);
        send(8'h08, 8'd20, 8'h00);
        send(8'h58, 8'h00, 8'h00);
        send(8'h48, 8'h00, 8'h00);
        send(8'h08, 8'h00, 8'h7F);
        send(8'h28, 8'h00, 8'h80);
        idle(4);
        check_state("clamp");
        chk("clamp_x_abs", int'(mouse_x), 159);
        chk("clamp_y_abs", int'(mouse_y), 119);

        send(8'h01, 8'h10, 8'h00);
        idle(4);
        check_state("bad_pkt");
        chk("bad_err_abs", int'(err_cnt), 1);
        for (int i = 0; i < 256; i++) send(8'h00, 8'(i), 8'h00);
        idle(4);
        check_state("err_sat");
        chk("err_sat_abs", int'(err_cnt), 255);

        do_reset();
        drive_cycle(1'b1, {8'h00, 8'h20, 8'h0B}, 1'b1);
        idle(4);
        check_state("centre");

        do_reset();
        send(8'h08, 8'h01, 8'h00);
        send(8'h08, 8'h01, 8'h00);
        send(8'h08, 8'h01, 8'h00);
        idle(4);
        check_state("b2b");
        chk("b2b_x_abs", int'(mouse_x), 83);

        do_reset();
        send(8'h08, 8'h01, 8'h00);
        send(8'h08, 8'h01, 8'h00);
        send(8'h08, 8'h01, 8'h00);
        do_reset();
        idle(4);
        check_state("mid_reset");

        do_reset();
        for (int i = 0; i < 400; i++) begin
            st = 8'($urandom);
            st[3] = ($urandom_range(0, 7) != 0);
            drive_cycle($urandom_range(0, 9) < 6, {8'($urandom), 8'($urandom), st},
                        $urandom_range(0, 9) == 0);
        end
        idle(4);
        check_state("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
